// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single RAM data port between instruction fetch and load/store.
// One request is in flight at a time; reads hold mem_re for RD_LAT cycles, writes pulse mem_we once.
module mem_arbiter #(
    parameter int ALEN   = 64,
    parameter int DLEN   = 64,
    parameter int ILEN   = 32,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [ALEN-1:0] if_addr,
    output logic            if_rsp_valid,
    output logic [ILEN-1:0] if_rsp_data,

    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic [ALEN-1:0] ls_addr,
    input  logic            ls_we,
    input  logic [1:0]      ls_len,
    input  logic [DLEN-1:0] ls_wdata,
    output logic            ls_rsp_valid,
    output logic [DLEN-1:0] ls_rsp_data,

    output logic [ALEN-1:0] mem_addr,
    output logic [DLEN-1:0] mem_wdata,
    output logic [1:0]      mem_len,
    output logic            mem_we,
    output logic            mem_re,
    input  logic [DLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [3:0] LAT = 4'(RD_LAT);

    state_t     state;
    logic [3:0] cnt;
    // Source of the most recent grant; also identifies who owns the transaction in flight.
    logic       last_ls;

    // Load/store wins when it is the only requester, or on a tie when fetch was served last.
    function automatic logic pick_ls(input logic ifv, input logic lsv, input logic prev_ls);
        return lsv && (!ifv || !prev_ls);
    endfunction

    always_comb begin
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;
        if (!rst && state == IDLE) begin
            ls_req_ready = pick_ls(if_req_valid, ls_req_valid, last_ls);
            if_req_ready = if_req_valid && !ls_req_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            last_ls      <= 1'b1;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_len      <= 2'b00;
            mem_we       <= 1'b0;
            mem_re       <= 1'b0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req_ready) begin
                        mem_addr <= if_addr;
                        mem_len  <= 2'b11;
                        last_ls  <= 1'b0;
                        cnt      <= LAT;
                        mem_re   <= 1'b1;
                        state    <= READ;
                    end else if (ls_req_ready) begin
                        mem_addr  <= ls_addr;
                        mem_len   <= ls_len;
                        mem_wdata <= ls_wdata;
                        last_ls   <= 1'b1;
                        if (ls_we) begin
                            mem_we <= 1'b1;
                            state  <= WRITE;
                        end else begin
                            cnt    <= LAT;
                            mem_re <= 1'b1;
                            state  <= READ;
                        end
                    end
                end
                READ: begin
                    cnt <= cnt - 4'd1;
                    // Last read cycle: capture the RAM data as it stands at this edge.
                    if (cnt == 4'd1) begin
                        mem_re <= 1'b0;
                        state  <= RESP;
                        if (last_ls) begin
                            ls_rsp_data  <= mem_rdata;
                            ls_rsp_valid <= 1'b1;
                        end else begin
                            if_rsp_data  <= mem_rdata[ILEN-1:0];
                            if_rsp_valid <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    mem_we       <= 1'b0;
                    ls_rsp_data  <= '0;
                    ls_rsp_valid <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if_rsp_valid <= 1'b0;
                    ls_rsp_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RD_LAT=1, a second with RD_LAT=3.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_chk = 0;
    int          n_fail = 0;

    logic        if_req_valid = 0, ls_req_valid = 0, ls_we = 0;
    logic [63:0] if_addr = 0, ls_addr = 0, ls_wdata = 0;
    logic [1:0]  ls_len = 0;
    logic [63:0] mem_rdata = 64'h1122334455667788;
    logic        if_req_ready, if_rsp_valid, ls_req_ready, ls_rsp_valid, mem_we, mem_re;
    logic [31:0] if_rsp_data;
    logic [63:0] ls_rsp_data, mem_addr, mem_wdata;
    logic [1:0]  mem_len;

    logic        if_req_valid3 = 0, ls_req_valid3 = 0, ls_we3 = 0;
    logic [63:0] if_addr3 = 0, ls_addr3 = 0, ls_wdata3 = 0;
    logic [1:0]  ls_len3 = 0;
    logic [63:0] mem_rdata3 = 64'h1111;
    logic        if_req_ready3, if_rsp_valid3, ls_req_ready3, ls_rsp_valid3, mem_we3, mem_re3;
    logic [31:0] if_rsp_data3;
    logic [63:0] ls_rsp_data3, mem_addr3, mem_wdata3;
    logic [1:0]  mem_len3;

    always #5 clk = ~clk;

    mem_arbiter #(.ALEN(64), .DLEN(64), .ILEN(32), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_we(ls_we), .ls_len(ls_len), .ls_wdata(ls_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_len(mem_len),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ALEN(64), .DLEN(64), .ILEN(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid3), .if_req_ready(if_req_ready3), .if_addr(if_addr3),
        .if_rsp_valid(if_rsp_valid3), .if_rsp_data(if_rsp_data3),
        .ls_req_valid(ls_req_valid3), .ls_req_ready(ls_req_ready3), .ls_addr(ls_addr3),
        .ls_we(ls_we3), .ls_len(ls_len3), .ls_wdata(ls_wdata3),
        .ls_rsp_valid(ls_rsp_valid3), .ls_rsp_data(ls_rsp_data3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_len(mem_len3),
        .mem_we(mem_we3), .mem_re(mem_re3), .mem_rdata(mem_rdata3)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick(); tick(); tick();
        chk("rst_if_rsp_valid", 64'(if_rsp_valid), 0);
        chk("rst_ls_rsp_valid", 64'(ls_rsp_valid), 0);
        chk("rst_mem_re", 64'(mem_re), 0);
        chk("rst_mem_we", 64'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_len", 64'(mem_len), 0);
        chk("rst_if_rsp_data", 64'(if_rsp_data), 0);
        chk("rst_ls_rsp_data", ls_rsp_data, 0);
        rst = 1'b0;
        #1;
        chk("idle_if_ready", 64'(if_req_ready), 0);
        chk("idle_ls_ready", 64'(ls_req_ready), 0);

        // Single fetch at 0x10
        tick();
        if_req_valid = 1; if_addr = 64'h10;
        #1;
        chk("f_if_ready", 64'(if_req_ready), 1);
        chk("f_ls_ready", 64'(ls_req_ready), 0);
        tick();
        if_req_valid = 0;
        #1;
        chk("f_c1_mem_re", 64'(mem_re), 1);
        chk("f_c1_mem_addr", mem_addr, 64'h10);
        chk("f_c1_mem_len", 64'(mem_len), 3);
        chk("f_c1_rsp", 64'(if_rsp_valid), 0);
        chk("f_c1_ready", 64'(if_req_ready), 0);
        tick();
        chk("f_c2_rsp", 64'(if_rsp_valid), 1);
        chk("f_c2_data", 64'(if_rsp_data), 64'h55667788);
        chk("f_c2_ls_rsp", 64'(ls_rsp_valid), 0);
        chk("f_c2_mem_re", 64'(mem_re), 0);
        tick();
        chk("f_c3_rsp", 64'(if_rsp_valid), 0);
        chk("f_c3_data_hold", 64'(if_rsp_data), 64'h55667788);

        // Store at 0x20, 4 bytes
        ls_req_valid = 1; ls_we = 1; ls_addr = 64'h20; ls_len = 2'b10;
        ls_wdata = 64'hDEADBEEF00000000;
        #1;
        chk("s_ls_ready", 64'(ls_req_ready), 1);
        chk("s_if_ready", 64'(if_req_ready), 0);
        tick();
        ls_req_valid = 0;
        #1;
        chk("s_c1_mem_we", 64'(mem_we), 1);
        chk("s_c1_mem_re", 64'(mem_re), 0);
        chk("s_c1_mem_addr", mem_addr, 64'h20);
        chk("s_c1_mem_len", 64'(mem_len), 2);
        chk("s_c1_mem_wdata", mem_wdata, 64'hDEADBEEF00000000);
        tick();
        chk("s_c2_mem_we", 64'(mem_we), 0);
        chk("s_c2_rsp", 64'(ls_rsp_valid), 1);
        chk("s_c2_data", ls_rsp_data, 0);
        chk("s_c2_if_rsp", 64'(if_rsp_valid), 0);
        chk("s_c2_mem_wdata", mem_wdata, 64'hDEADBEEF00000000);
        tick();
        chk("s_c3_rsp", 64'(ls_rsp_valid), 0);
        ls_we = 0;

        // Both valid continuously from reset: IF, LS, IF, LS, each a 3-cycle read
        rst = 1;
        tick();
        rst = 0;
        if_req_valid = 1; if_addr = 64'h100;
        ls_req_valid = 1; ls_addr = 64'h200; ls_len = 2'b11;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("rr%0d_if_ready", c), 64'(if_req_ready), 64'((c % 6) == 0));
            chk($sformatf("rr%0d_ls_ready", c), 64'(ls_req_ready), 64'((c % 6) == 3));
            chk($sformatf("rr%0d_if_rsp", c), 64'(if_rsp_valid), 64'((c % 6) == 2));
            chk($sformatf("rr%0d_ls_rsp", c), 64'(ls_rsp_valid), 64'((c % 6) == 5));
            if ((c % 6) == 1) chk($sformatf("rr%0d_addr", c), mem_addr, 64'h100);
            if ((c % 6) == 4) chk($sformatf("rr%0d_addr", c), mem_addr, 64'h200);
            if ((c % 6) == 2) chk($sformatf("rr%0d_if_data", c), 64'(if_rsp_data), 64'h55667788);
            if ((c % 6) == 5) chk($sformatf("rr%0d_ls_data", c), ls_rsp_data, 64'h1122334455667788);
            tick();
        end
        if_req_valid = 0; ls_req_valid = 0;

        // Reset during a fetch READ: no response, then fetch wins the tie
        tick();
        if_req_valid = 1; if_addr = 64'h300;
        #1;
        chk("ra_if_ready", 64'(if_req_ready), 1);
        tick();
        if_req_valid = 0; rst = 1;
        #1;
        chk("ra_mem_re_before", 64'(mem_re), 1);
        tick();
        rst = 0;
        if_req_valid = 1; if_addr = 64'h400;
        ls_req_valid = 1; ls_addr = 64'h500;
        #1;
        chk("ra_mem_re_after", 64'(mem_re), 0);
        chk("ra_if_rsp", 64'(if_rsp_valid), 0);
        chk("ra_ls_rsp", 64'(ls_rsp_valid), 0);
        chk("ra_tie_if_ready", 64'(if_req_ready), 1);
        chk("ra_tie_ls_ready", 64'(ls_req_ready), 0);
        tick();
        if_req_valid = 0; ls_req_valid = 0;
        #1;
        chk("ra_grant_addr", mem_addr, 64'h400);
        chk("ra_c1_if_rsp", 64'(if_rsp_valid), 0);
        tick();
        chk("ra_c2_if_rsp", 64'(if_rsp_valid), 1);
        chk("ra_c2_ls_rsp", 64'(ls_rsp_valid), 0);
        tick();

        // Load/store toggles valid while a fetch is in flight
        if_req_valid = 1; if_addr = 64'h30;
        #1;
        chk("b_if_ready", 64'(if_req_ready), 1);
        tick();
        if_req_valid = 0;
        ls_req_valid = 1; ls_we = 1; ls_addr = 64'h99; ls_len = 2'b00; ls_wdata = 64'h77;
        #1;
        chk("b_c1_ls_ready", 64'(ls_req_ready), 0);
        chk("b_c1_mem_addr", mem_addr, 64'h30);
        tick();
        ls_req_valid = 0;
        #1;
        chk("b_c2_ls_ready", 64'(ls_req_ready), 0);
        chk("b_c2_mem_addr", mem_addr, 64'h30);
        chk("b_c2_mem_len", 64'(mem_len), 3);
        chk("b_c2_if_rsp", 64'(if_rsp_valid), 1);
        tick();
        chk("b_c3_mem_we", 64'(mem_we), 0);
        chk("b_c3_mem_addr", mem_addr, 64'h30);
        tick();
        chk("b_c4_mem_we", 64'(mem_we), 0);
        chk("b_c4_ls_rsp", 64'(ls_rsp_valid), 0);
        tick();
        chk("b_c5_ls_rsp", 64'(ls_rsp_valid), 0);
        ls_we = 0;

        // RD_LAT=3 load at 0x40, data changes before the last read cycle
        ls_req_valid3 = 1; ls_we3 = 0; ls_addr3 = 64'h40; ls_len3 = 2'b11;
        #1;
        chk("l3_ls_ready", 64'(ls_req_ready3), 1);
        tick();
        ls_req_valid3 = 0;
        #1;
        chk("l3_c1_mem_re", 64'(mem_re3), 1);
        chk("l3_c1_mem_addr", mem_addr3, 64'h40);
        tick();
        chk("l3_c2_mem_re", 64'(mem_re3), 1);
        chk("l3_c2_rsp", 64'(ls_rsp_valid3), 0);
        tick();
        mem_rdata3 = 64'hA5A5;
        chk("l3_c3_mem_re", 64'(mem_re3), 1);
        chk("l3_c3_rsp", 64'(ls_rsp_valid3), 0);
        tick();
        chk("l3_c4_mem_re", 64'(mem_re3), 0);
        chk("l3_c4_rsp", 64'(ls_rsp_valid3), 1);
        chk("l3_c4_data", ls_rsp_data3, 64'hA5A5);
        chk("l3_c4_if_rsp", 64'(if_rsp_valid3), 0);
        tick();
        chk("l3_c5_rsp", 64'(ls_rsp_valid3), 0);
        chk("l3_c5_data_hold", ls_rsp_data3, 64'hA5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
